// File: rtl/fast_pkg.sv
// Shared FAST-format definitions: word width, header codes, arbiter state
// encoding and a header extraction helper.
package fast_pkg;

    localparam int FAST_DW = 134;

    localparam logic [1:0] HDR_FIRST = 2'b01;
    localparam logic [1:0] HDR_MID   = 2'b11;
    localparam logic [1:0] HDR_LAST  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } arb_state_e;

    function automatic logic [1:0] fast_hdr(input logic [FAST_DW-1:0] word);
        return word[FAST_DW-1 -: 2];
    endfunction

endpackage

// File: rtl/fast_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    localparam int SW = IW + 1;

    logic [SW-1:0] pos;

    // Scan from the farthest offset down so the closest requester wins last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + SW'(k);
            if (pos >= SW'(N)) begin
                pos = pos - SW'(N);
            end
            if (req[pos[IW-1:0]]) begin
                idx = pos[IW-1:0];
                any = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_gnt
        assign gnt[gi] = any & (idx == IW'(gi));
    end

endmodule

// File: rtl/fast_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging N_PORTS FAST sources onto one sink.
// One port owns the sink from grant until its end-of-packet strobe.
module fast_rr_arbiter
    import fast_pkg::*;
#(
    parameter int N_PORTS       = 4,
    parameter int DW            = FAST_DW,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [N_PORTS-1:0]       in_req,
    output logic [N_PORTS-1:0]       in_ready,
    input  logic [N_PORTS-1:0]       in_data_wr,
    input  logic [N_PORTS*DW-1:0]    in_data,
    input  logic [N_PORTS-1:0]       in_valid_wr,
    input  logic [N_PORTS-1:0]       in_valid,
    output logic                     out_data_wr,
    output logic [DW-1:0]            out_data,
    output logic                     out_valid_wr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(N_PORTS)-1:0] grant_id,
    output logic                     proto_err,
    output logic [31:0]              pkt_cnt
);

    localparam int IW = $clog2(N_PORTS);
    localparam int TW = $clog2(GRANT_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [N_PORTS-1:0] ready_q, ready_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               last_seen_q, last_seen_d;
    logic               odwr_q, odwr_d;
    logic [DW-1:0]      odata_q, odata_d;
    logic               ovwr_q, ovwr_d;
    logic               ovalid_q, ovalid_d;

    logic [DW-1:0]      port_word [N_PORTS];
    logic [N_PORTS-1:0] stray;
    logic [N_PORTS-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               active;
    logic               sel_dwr;
    logic               sel_vwr;
    logic               sel_valid;
    logic [DW-1:0]      sel_word;
    logic [1:0]         sel_hdr;
    logic               hdr_err;
    logic [IW-1:0]      next_ptr;

    rr_pick #(
        .N  (N_PORTS),
        .IW (IW)
    ) u_pick (
        .req (in_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign active = (state_q == GRANT) || (state_q == XFER);

    // Strobes from any port that does not currently own the sink are errors.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        assign port_word[gi] = in_data[gi*DW +: DW];
        assign stray[gi]     = (in_data_wr[gi] | in_valid_wr[gi])
                             & ~(active & (grant_q == IW'(gi)));
    end

    assign sel_dwr   = in_data_wr[grant_q];
    assign sel_vwr   = in_valid_wr[grant_q];
    assign sel_valid = in_valid[grant_q];
    assign sel_word  = port_word[grant_q];
    assign sel_hdr   = fast_hdr(sel_word);
    assign next_ptr  = (grant_q == IW'(N_PORTS - 1)) ? '0 : grant_q + 1'b1;

    // A packet must open with FIRST and carry no words after its LAST word.
    assign hdr_err = active & sel_dwr
                   & (((state_q == GRANT) & (sel_hdr != HDR_FIRST))
                    | ((state_q == XFER) & last_seen_q));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        ready_d     = ready_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        last_seen_d = last_seen_q;
        err_d       = err_q | (|stray) | hdr_err;
        odwr_d      = active & sel_dwr;
        odata_d     = (active & sel_dwr) ? sel_word : '0;
        ovwr_d      = active & sel_vwr;
        ovalid_d    = active & sel_vwr & sel_valid;

        unique case (state_q)
            IDLE: begin
                if (out_ready && pick_any) begin
                    grant_d     = pick_idx;
                    ready_d     = pick_gnt;
                    timer_d     = '0;
                    last_seen_d = 1'b0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (sel_dwr) begin
                    ready_d     = '0;
                    last_seen_d = (sel_hdr == HDR_LAST);
                    if (sel_vwr) begin
                        cnt_d   = cnt_q + 32'd1;
                        ptr_d   = next_ptr;
                        state_d = IDLE;
                    end else begin
                        state_d = XFER;
                    end
                end else if (timer_q == TW'(GRANT_TIMEOUT - 1)) begin
                    ready_d = '0;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            XFER: begin
                if (sel_dwr && (sel_hdr == HDR_LAST)) begin
                    last_seen_d = 1'b1;
                end
                if (sel_vwr) begin
                    cnt_d   = cnt_q + 32'd1;
                    ptr_d   = next_ptr;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            ready_q     <= '0;
            timer_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            odwr_q      <= 1'b0;
            odata_q     <= '0;
            ovwr_q      <= 1'b0;
            ovalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            odwr_q      <= odwr_d;
            odata_q     <= odata_d;
            ovwr_q      <= ovwr_d;
            ovalid_q    <= ovalid_d;
        end
    end

    assign in_ready     = ready_q;
    assign out_data_wr  = odwr_q;
    assign out_data     = odata_q;
    assign out_valid_wr = ovwr_q;
    assign out_valid    = ovalid_q;
    assign grant_id     = grant_q;
    assign proto_err    = err_q;
    assign pkt_cnt      = cnt_q;

endmodule

// File: tb/tb_fast_rr_arbiter.sv
// Directed bench for fast_rr_arbiter: transaction-level reference model checked
// every cycle, plus hand-computed expectations per scenario.
module tb_fast_rr_arbiter;
    import fast_pkg::*;

    localparam int N  = 4;
    localparam int DW = 134;
    localparam int TO = 64;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic [N-1:0]    in_req = '0;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    in_data_wr = '0;
    logic [N*DW-1:0] in_data = '0;
    logic [N-1:0]    in_valid_wr = '0;
    logic [N-1:0]    in_valid = '0;
    logic            out_data_wr;
    logic [DW-1:0]   out_data;
    logic            out_valid_wr;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [1:0]      grant_id;
    logic            proto_err;
    logic [31:0]     pkt_cnt;

    int checks = 0;
    int errors = 0;

    fast_rr_arbiter #(.N_PORTS(N), .DW(DW), .GRANT_TIMEOUT(TO)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .in_req       (in_req),
        .in_ready     (in_ready),
        .in_data_wr   (in_data_wr),
        .in_data      (in_data),
        .in_valid_wr  (in_valid_wr),
        .in_valid     (in_valid),
        .out_data_wr  (out_data_wr),
        .out_data     (out_data),
        .out_valid_wr (out_valid_wr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant_id     (grant_id),
        .proto_err    (proto_err),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Packet word builder: header/inv per position, payload tags port and index.
    function automatic logic [DW-1:0] mk(input int p, input int k, input int len, input logic [3:0] inv);
        logic [DW-1:0] w;
        w = '0;
        w[133:132] = (k == 0) ? 2'b01 : ((k == len - 1) ? 2'b10 : 2'b11);
        w[131:128] = (k == len - 1) ? inv : 4'h0;
        w[127:0]   = {32'(p), 32'(k), 32'(len), 32'hC0DE_0000 + 32'(p * 16 + k)};
        return w;
    endfunction

    // ---------------- reference model ----------------
    int            m_owner;
    int            m_ptr;
    int            m_waited;
    bit            m_started;
    bit            m_saw_last;
    logic [N-1:0]  e_ready;
    logic          e_dwr, e_vwr, e_valid, e_err;
    logic [DW-1:0] e_data;
    logic [1:0]    e_gid;
    logic [31:0]   e_cnt;
    logic [DW-1:0] m_w;

    task automatic model_step();
        bit found;
        if (!aresetn) begin
            m_owner = -1; m_ptr = 0; m_waited = 0; m_started = 0; m_saw_last = 0;
            e_ready = '0; e_dwr = 0; e_vwr = 0; e_valid = 0; e_err = 0;
            e_data = '0; e_gid = '0; e_cnt = '0;
            return;
        end
        if (m_owner >= 0) begin
            e_dwr   = in_data_wr[m_owner];
            e_data  = e_dwr ? in_data[m_owner*DW +: DW] : '0;
            e_vwr   = in_valid_wr[m_owner];
            e_valid = e_vwr & in_valid[m_owner];
        end else begin
            e_dwr = 0; e_data = '0; e_vwr = 0; e_valid = 0;
        end
        for (int i = 0; i < N; i++) begin
            if ((in_data_wr[i] || in_valid_wr[i]) && i != m_owner) e_err = 1;
        end
        if (m_owner >= 0 && in_data_wr[m_owner]) begin
            m_w = in_data[m_owner*DW +: DW];
            if (!m_started && m_w[133:132] != 2'b01) e_err = 1;
            if (m_started && m_saw_last) e_err = 1;
            if (m_w[133:132] == 2'b10) m_saw_last = 1;
        end
        if (m_owner < 0) begin
            if (out_ready && in_req != 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && in_req[(m_ptr + k) % N]) begin
                        found = 1;
                        m_owner = (m_ptr + k) % N;
                    end
                end
                m_started = 0; m_waited = 0; m_saw_last = 0;
                e_gid = 2'(m_owner);
                e_ready = '0;
                e_ready[m_owner] = 1'b1;
            end
        end else if (!m_started) begin
            if (in_data_wr[m_owner]) begin
                m_started = 1;
                e_ready = '0;
                if (in_valid_wr[m_owner]) begin
                    e_cnt++; m_ptr = (m_owner + 1) % N; m_owner = -1;
                end
            end else begin
                m_waited++;
                if (m_waited == TO) begin
                    e_ready = '0; m_ptr = (m_owner + 1) % N; m_owner = -1;
                end
            end
        end else if (in_valid_wr[m_owner]) begin
            e_cnt++; m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
    endtask

    initial begin
        model_step();
        forever begin
            @(posedge aclk or negedge aresetn);
            model_step();
        end
    end

    // ---------------- compare + monitor ----------------
    logic [DW-1:0] cap[$];
    int            r1_cnt, r3_cnt, pkt_words;

    initial begin
        forever begin
            @(negedge aclk);
            chk("in_ready", DW'(in_ready), DW'(e_ready));
            chk("out_data_wr", DW'(out_data_wr), DW'(e_dwr));
            chk("out_data", out_data, e_data);
            chk("out_valid_wr", DW'(out_valid_wr), DW'(e_vwr));
            chk("out_valid", DW'(out_valid), DW'(e_valid));
            chk("grant_id", DW'(grant_id), DW'(e_gid));
            chk("proto_err", DW'(proto_err), DW'(e_err));
            chk("pkt_cnt", DW'(pkt_cnt), DW'(e_cnt));
            if (in_ready[1]) r1_cnt++;
            if (in_ready[3]) r3_cnt++;
            if (out_data_wr) begin
                cap.push_back(out_data);
                pkt_words++;
            end
            if (out_valid_wr) begin
                $display("pkt port=%0d words=%0d pkt_cnt=%0d", grant_id, pkt_words, pkt_cnt);
                pkt_words = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int       plen[N];
    int       pend[N];
    logic [3:0] pinv[N];
    int       sent_order[$];

    task automatic clear_inputs();
        in_req = '0; in_data_wr = '0; in_data = '0; in_valid_wr = '0; in_valid = '0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin plen[i] = 2; pend[i] = 0; pinv[i] = 4'h0; end
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        cap.delete(); sent_order.delete();
        r1_cnt = 0; r3_cnt = 0; pkt_words = 0;
    endtask

    // Called at the negedge where in_ready[p] is seen; intr>=0 injects a stray word.
    task automatic send_packet(input int p, input int intr);
        for (int k = 0; k < plen[p]; k++) begin
            in_data[p*DW +: DW] = mk(p, k, plen[p], pinv[p]);
            in_data_wr[p]  = 1'b1;
            in_valid_wr[p] = (k == plen[p] - 1);
            in_valid[p]    = (k == plen[p] - 1);
            if (intr >= 0) begin
                in_data_wr[intr] = (k == 1);
                in_data[intr*DW +: DW] = (k == 1) ? mk(intr, 9, 10, 4'h0) : '0;
            end
            @(negedge aclk);
        end
        in_data_wr = '0; in_valid_wr = '0; in_valid = '0; in_data = '0;
        pend[p]--;
        if (pend[p] == 0) in_req[p] = 1'b0;
        sent_order.push_back(p);
    endtask

    task automatic serve(input int npk, input int budget, input int intr);
        int sent, cyc, p;
        sent = 0; cyc = 0;
        while (sent < npk && cyc < budget) begin
            @(negedge aclk);
            cyc++;
            p = -1;
            for (int i = 0; i < N; i++) if (in_ready[i]) p = i;
            if (p >= 0) begin
                send_packet(p, intr);
                sent++;
            end
        end
        chk("serve_done", DW'(sent), DW'(npk));
    endtask

    task automatic wait_ready(input int p, input int budget);
        int cyc;
        cyc = 0;
        while (!in_ready[p] && cyc < budget) begin
            @(negedge aclk);
            cyc++;
        end
        chk("wait_ready", DW'(in_ready[p]), DW'(1));
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        // reset state
        aresetn = 1'b0;
        @(negedge aclk);
        chk("rst_in_ready", DW'(in_ready), DW'(0));
        chk("rst_out_data_wr", DW'(out_data_wr), DW'(0));
        chk("rst_grant_id", DW'(grant_id), DW'(0));
        chk("rst_pkt_cnt", DW'(pkt_cnt), DW'(0));

        // single 3-word packet from port 1
        do_reset();
        out_ready = 1'b1;
        plen[1] = 3; pinv[1] = 4'b0011; pend[1] = 1; in_req[1] = 1'b1;
        serve(1, 20, -1);
        repeat (2) @(negedge aclk);
        chk("t1_ready_cycles", DW'(r1_cnt), DW'(1));
        chk("t1_pkt_cnt", DW'(pkt_cnt), DW'(1));
        chk("t1_words", DW'(cap.size()), DW'(3));
        for (int k = 0; k < 3 && k < cap.size(); k++)
            chk("t1_word", cap[k], mk(1, k, 3, 4'b0011));

        // all four ports requesting: order 0,1,2,3,0
        do_reset();
        out_ready = 1'b1;
        pend[0] = 2; pend[1] = 1; pend[2] = 1; pend[3] = 1;
        in_req = 4'b1111;
        serve(5, 200, -1);
        repeat (2) @(negedge aclk);
        chk("t2_pkt_cnt", DW'(pkt_cnt), DW'(5));
        chk("t2_order_len", DW'(sent_order.size()), DW'(5));
        for (int i = 0; i < 5 && i < sent_order.size(); i++)
            chk("t2_order", DW'(sent_order[i]), DW'(exp_ord[i]));
        chk("t2_words", DW'(cap.size()), DW'(10));
        for (int i = 0; i < 10 && i < cap.size(); i++)
            chk("t2_word", cap[i], mk(exp_ord[i/2], i % 2, 2, 4'h0));

        // out_ready low blocks the grant
        do_reset();
        pend[2] = 1; in_req = 4'b0100;
        repeat (5) @(negedge aclk);
        chk("t3_blocked", DW'(in_ready), DW'(0));
        out_ready = 1'b1;
        wait_ready(2, 2);
        chk("t3_ready", DW'(in_ready), DW'(4'b0100));
        chk("t3_grant_id", DW'(grant_id), DW'(2));
        serve(1, 10, -1);

        // grant timeout on port 3, port 0 next
        do_reset();
        out_ready = 1'b1;
        pend[3] = 1; in_req = 4'b1000;
        wait_ready(3, 5);
        in_req = 4'b0001; pend[3] = 0; pend[0] = 1;
        for (int c = 0; c < 80 && in_ready[3]; c++) @(negedge aclk);
        chk("t4_ready_cycles", DW'(r3_cnt), DW'(TO));
        chk("t4_pkt_cnt", DW'(pkt_cnt), DW'(0));
        chk("t4_proto_err", DW'(proto_err), DW'(0));
        serve(1, 10, -1);
        chk("t4_next_port", DW'(sent_order.size() > 0 ? sent_order[0] : -1), DW'(0));
        repeat (2) @(negedge aclk);
        chk("t4_pkt_after", DW'(pkt_cnt), DW'(1));

        // stray data from port 0 while port 1 owns the sink
        do_reset();
        out_ready = 1'b1;
        plen[1] = 4; pend[1] = 1; in_req = 4'b0010;
        serve(1, 10, 0);
        repeat (2) @(negedge aclk);
        chk("t5_proto_err", DW'(proto_err), DW'(1));
        chk("t5_words", DW'(cap.size()), DW'(4));
        for (int k = 0; k < 4 && k < cap.size(); k++)
            chk("t5_word", cap[k], mk(1, k, 4, 4'h0));
        repeat (3) @(negedge aclk);
        chk("t5_sticky", DW'(proto_err), DW'(1));

        // asynchronous reset mid-packet, then a clean packet
        do_reset();
        out_ready = 1'b1;
        plen[0] = 4; pend[0] = 1; in_req = 4'b0001;
        wait_ready(0, 5);
        in_data[0 +: DW] = mk(0, 0, 4, 4'h0); in_data_wr[0] = 1'b1;
        @(negedge aclk);
        in_data[0 +: DW] = mk(0, 1, 4, 4'h0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_out_data_wr", DW'(out_data_wr), DW'(0));
        chk("t6_out_data", out_data, '0);
        chk("t6_in_ready", DW'(in_ready), DW'(0));
        chk("t6_out_valid_wr", DW'(out_valid_wr), DW'(0));
        clear_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
        cap.delete();
        plen[0] = 4; pend[0] = 1; in_req = 4'b0001;
        serve(1, 20, -1);
        repeat (2) @(negedge aclk);
        chk("t6_words", DW'(cap.size()), DW'(4));
        for (int k = 0; k < 4 && k < cap.size(); k++)
            chk("t6_word", cap[k], mk(0, k, 4, 4'h0));
        chk("t6_pkt_cnt", DW'(pkt_cnt), DW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
